// File: rtl/crc5_receiver.sv
//-----------------------------------------------------------------------------
// crc5_receiver: serial 16-bit frame receiver (11 payload bits + inverted CRC-5)
// Revision: 1.0
//-----------------------------------------------------------------------------
`default_nettype none

module crc5_receiver (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        in_valid,
   input  logic        in,
   output logic [10:0] data,
   output logic        valid,
   output logic        ok,
   output logic        err,
   output logic        busy,
   output logic        abort
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      CRC  = 2'd2
   } state_t;

   localparam logic [4:0] CRC_INIT    = 5'b11111;
   localparam logic [4:0] CRC_RESIDUE = 5'b01100;
   localparam logic [3:0] LAST_DATA   = 4'd10;
   localparam logic [3:0] LAST_BIT    = 4'd15;

   state_t      state;
   logic [3:0]  cnt;
   logic [4:0]  crc;
   logic [10:0] payload;
   logic [4:0]  crc_next;

   function automatic logic [4:0] crc_step(input logic [4:0] c, input logic b);
      logic fb;
      fb = b ^ c[4];
      return {c[3], c[2], c[1] ^ fb, c[0], fb};
   endfunction

   // A start bit always seeds from the initial value, so a restart mid-frame
   // discards whatever the register held.
   assign crc_next = crc_step(start ? CRC_INIT : crc, in);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         crc     <= CRC_INIT;
         payload <= 11'd0;
         data    <= 11'd0;
         valid   <= 1'b0;
         ok      <= 1'b0;
         err     <= 1'b0;
         busy    <= 1'b0;
         abort   <= 1'b0;
      end else begin
         valid <= 1'b0;
         abort <= 1'b0;
         if (in_valid) begin
            if (start) begin
               abort   <= (state != IDLE);
               state   <= DATA;
               cnt     <= 4'd1;
               crc     <= crc_next;
               payload <= {10'd0, in};
               busy    <= 1'b1;
            end else if (state == DATA) begin
               crc     <= crc_next;
               payload <= {payload[9:0], in};
               cnt     <= cnt + 4'd1;
               if (cnt == LAST_DATA) begin
                  state <= CRC;
               end
            end else if (state == CRC) begin
               crc <= crc_next;
               if (cnt == LAST_BIT) begin
                  state <= IDLE;
                  cnt   <= 4'd0;
                  busy  <= 1'b0;
                  data  <= payload;
                  ok    <= (crc_next == CRC_RESIDUE);
                  err   <= (crc_next != CRC_RESIDUE);
                  valid <= 1'b1;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_crc5_receiver.sv
//-----------------------------------------------------------------------------
// tb_crc5_receiver: directed self-checking bench for crc5_receiver
// Revision: 1.0
//-----------------------------------------------------------------------------
`default_nettype none

module tb_crc5_receiver;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        in_valid;
   logic        in_bit;
   logic [10:0] data;
   logic        valid;
   logic        ok;
   logic        err;
   logic        busy;
   logic        abort;

   int total = 0;
   int bad   = 0;
   int valid_cnt = 0;
   int abort_cnt = 0;
   int v0;
   int a0;

   crc5_receiver dut (
      .clk      (clk),
      .rst      (rst_n),
      .start    (start),
      .in_valid (in_valid),
      .in       (in_bit),
      .data     (data),
      .valid    (valid),
      .ok       (ok),
      .err      (err),
      .busy     (busy),
      .abort    (abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (valid) valid_cnt++;
      if (abort) abort_cnt++;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are read on the next falling edge.
   task automatic step(input logic v, input logic s, input logic b);
      in_valid = v;
      start    = s;
      in_bit   = b;
      @(negedge clk);
   endtask

   task automatic send_frame(input logic [15:0] f, input bit gaps);
      for (int i = 0; i < 16; i++) begin
         step(1'b1, (i == 0), f[15-i]);
         if (gaps && i < 15) begin
            for (int g = 0; g < (i % 3) + 1; g++) begin
               step(1'b0, 1'b0, 1'b0);
               chk("gap_busy", {15'd0, busy}, 16'd1);
            end
         end
      end
      in_valid = 1'b0;
      start    = 1'b0;
   endtask

   task automatic check_done(input string tag, input logic [10:0] exp_data, input logic exp_ok);
      chk({tag, "_valid"}, {15'd0, valid}, 16'd1);
      chk({tag, "_data"},  {5'd0, data},   {5'd0, exp_data});
      chk({tag, "_ok"},    {15'd0, ok},    {15'd0, exp_ok});
      chk({tag, "_err"},   {15'd0, err},   {15'd0, ~exp_ok});
      chk({tag, "_busy"},  {15'd0, busy},  16'd0);
      step(1'b0, 1'b0, 1'b0);
      chk({tag, "_valid_drop"}, {15'd0, valid}, 16'd0);
   endtask

   initial begin
      logic [15:0] f;
      rst_n    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_bit   = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_data",  {5'd0, data},   16'd0);
      chk("rst_valid", {15'd0, valid}, 16'd0);
      chk("rst_ok",    {15'd0, ok},    16'd0);
      chk("rst_err",   {15'd0, err},   16'd0);
      chk("rst_busy",  {15'd0, busy},  16'd0);
      chk("rst_abort", {15'd0, abort}, 16'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Clean frame, zero payload
      v0 = valid_cnt;
      send_frame(16'h0008, 1'b0);
      check_done("good0", 11'h000, 1'b1);
      chk("good0_pulses", valid_cnt[15:0] - v0[15:0], 16'd1);

      // Payload 100_0000_0000; CRC of it is 01000, inverted check 10111
      send_frame(16'h8017, 1'b0);
      check_done("good400", 11'h400, 1'b1);

      // Gaps of 1-3 idle cycles between bits
      v0 = valid_cnt;
      send_frame(16'h0008, 1'b1);
      check_done("gaps", 11'h000, 1'b1);
      chk("gaps_pulses", valid_cnt[15:0] - v0[15:0], 16'd1);

      // One check bit flipped
      send_frame(16'h0009, 1'b0);
      check_done("bad", 11'h000, 1'b0);

      // Restart after 7 bits
      v0 = valid_cnt;
      a0 = abort_cnt;
      f  = 16'h8017;
      for (int i = 0; i < 7; i++) step(1'b1, (i == 0), f[15-i]);
      chk("pre_abort_busy", {15'd0, busy}, 16'd1);
      f = 16'h0008;
      step(1'b1, 1'b1, f[15]);
      chk("abort_pulse", {15'd0, abort}, 16'd1);
      chk("abort_busy",  {15'd0, busy},  16'd1);
      chk("abort_ok",    {15'd0, ok},    16'd0);
      chk("abort_err",   {15'd0, err},   16'd1);
      for (int i = 1; i < 16; i++) begin
         step(1'b1, 1'b0, f[15-i]);
         if (i == 1) chk("abort_drop", {15'd0, abort}, 16'd0);
      end
      in_valid = 1'b0;
      check_done("restart", 11'h000, 1'b1);
      chk("restart_pulses", valid_cnt[15:0] - v0[15:0], 16'd1);
      chk("restart_aborts", abort_cnt[15:0] - a0[15:0], 16'd1);

      // Asynchronous reset mid-frame
      v0 = valid_cnt;
      a0 = abort_cnt;
      f  = 16'h8017;
      for (int i = 0; i < 12; i++) step(1'b1, (i == 0), f[15-i]);
      in_valid = 1'b0;
      chk("prerst_busy", {15'd0, busy}, 16'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_ok",    {15'd0, ok},    16'd0);
      chk("midrst_err",   {15'd0, err},   16'd0);
      chk("midrst_busy",  {15'd0, busy},  16'd0);
      chk("midrst_valid", {15'd0, valid}, 16'd0);
      chk("midrst_abort", {15'd0, abort}, 16'd0);
      chk("midrst_data",  {5'd0, data},   16'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_no_valid", valid_cnt[15:0] - v0[15:0], 16'd0);
      chk("midrst_no_abort", abort_cnt[15:0] - a0[15:0], 16'd0);
      send_frame(16'h0008, 1'b0);
      check_done("postrst", 11'h000, 1'b1);
      send_frame(16'h8017, 1'b0);
      check_done("postrst400", 11'h400, 1'b1);

      // Bits without start from IDLE are ignored
      v0 = valid_cnt;
      a0 = abort_cnt;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0, i[0] ^ i[2]);
         chk("nostart_busy", {15'd0, busy}, 16'd0);
      end
      step(1'b0, 1'b0, 1'b0);
      chk("nostart_valid", valid_cnt[15:0] - v0[15:0], 16'd0);
      chk("nostart_abort", abort_cnt[15:0] - a0[15:0], 16'd0);
      chk("nostart_data",  {5'd0, data}, 16'h0400);
      chk("nostart_ok",    {15'd0, ok},  16'd1);
      chk("nostart_err",   {15'd0, err}, 16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
